dmem_ctrl: RTL

- Load/store unit between the datapath memory port and an external word-wide data bus with a req/ack handshake.
- Consumes the datapath's ALU result as the address, its store data, and decoded load/store controls.
- Converts byte, halfword and word accesses into byte-enabled bus transactions and returns lane-extracted, sign- or zero-extended load data on `rd`.
- Holds the core with `stall` until the bus completes; flags misaligned, illegal and timed-out accesses on `fault`.

---
 rtl/dmem_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: load/store unit bridging the datapath memory port to a req/ack word bus
module dmem_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [7:0] TO = 8'(TIMEOUT);
  state_t state, state_nx;
  logic [7:0] cnt;
  logic [1:0] lo_q, size_q;
  logic err_q, ld_q, uns_q;
  logic req, err, hit_to;
  logic [3:0] be_nx;
  logic [31:0] wdata_nx, lane, ld_val;
  always_comb begin
    req = mem_re | mem_we;
    err = (mem_re & mem_we) | (mem_size == 2'b11) | (mem_size == 2'b01 & addr[0])
        | (mem_size == 2'b10 & |addr[1:0]);
    hit_to = !bus_ack && (cnt + 8'd1 == TO);
    be_nx = mem_size == 2'b00 ? 4'b0001 << addr[1:0]
          : mem_size == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
    wdata_nx = mem_size == 2'b00 ? {4{wd[7:0]}} : mem_size == 2'b01 ? {2{wd[15:0]}} : wd;
    lane = bus_rdata >> {lo_q, 3'b000};
    ld_val = size_q == 2'b00 ? {{24{!uns_q & lane[7]}}, lane[7:0]}
           : size_q == 2'b01 ? {{16{!uns_q & lane[15]}}, lane[15:0]} : bus_rdata;
    state_nx = state == IDLE ? (req ? (err ? DONE : BUSY) : IDLE)
             : state == BUSY ? ((bus_ack | hit_to) ? DONE : BUSY) : IDLE;
    // reset must drop stall even while the request is still being presented
    stall = !reset & ((state == IDLE & req) | state == BUSY);
    fault = state == DONE & err_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt <= '0;
      rd <= '0;
      err_q <= 1'b0;
      ld_q <= 1'b0;
      uns_q <= 1'b0;
      lo_q <= '0;
      size_q <= '0;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_be <= '0;
      bus_wdata <= '0;
    end else if (state == IDLE) begin
      err_q <= err;
      if (req & !err) begin
        bus_req <= 1'b1;
        bus_we <= mem_we;
        bus_addr <= {addr[31:2], 2'b00};
        bus_be <= be_nx;
        bus_wdata <= wdata_nx;
        cnt <= '0;
        ld_q <= mem_re;
        uns_q <= mem_unsigned;
        lo_q <= addr[1:0];
        size_q <= mem_size;
      end
    end else if (state == BUSY) begin
      if (bus_ack) begin
        bus_req <= 1'b0;
        err_q <= 1'b0;
        if (ld_q) rd <= ld_val;
      end else if (hit_to) begin
        bus_req <= 1'b0;
        err_q <= 1'b1;
        if (ld_q) rd <= '0;
      end else cnt <= cnt + 8'd1;
    end
endmodule
